// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: carry-chunked pipelined adder/subtractor, one chunk of CW=NBits/NStages bits per stage
//   clk                rising-edge clock
//   reset              asynchronous active-low reset
//   Enable             1 = pipeline advances, 0 = every stage holds
//   Flush              clears all in-flight operations at the next edge
//   In_Valid, Sub      new operation; Sub=1 computes Data0-Data1
//   Data0, Data1       operands
//   Out_Valid          Result/flags carry a completed operation
//   Result             sum or difference modulo 2^NBits
//   Carry_Out          carry out of the MSB (for Sub, 1 = no borrow)
//   Overflow, Zero     signed overflow, Result == 0
module pipelined_add_sub #(
  parameter int NBits   = 32,
  parameter int NStages = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Enable,
  input  logic             Flush,
  input  logic             In_Valid,
  input  logic             Sub,
  input  logic [NBits-1:0] Data0,
  input  logic [NBits-1:0] Data1,
  output logic             Out_Valid,
  output logic [NBits-1:0] Result,
  output logic             Carry_Out,
  output logic             Overflow,
  output logic             Zero
);
  localparam int CW = NBits / NStages;
  // Each stage keeps the full operands (b already inverted for Sub) so the
  // upper chunks and the sign bits travel with the partial sum; the last
  // stage's registers double as the output registers.
  logic [NBits-1:0] a_d [NStages];
  logic [NBits-1:0] a_q [NStages];
  logic [NBits-1:0] b_d [NStages];
  logic [NBits-1:0] b_q [NStages];
  logic [NBits-1:0] s_d [NStages];
  logic [NBits-1:0] s_q [NStages];
  logic             c_d [NStages];
  logic             c_q [NStages];
  logic             v_d [NStages];
  logic             v_q [NStages];
  logic             ovf_d, ovf_q, zero_d, zero_q;
  logic [NBits-1:0] a_in, b_in, s_in, sum_n;
  logic             c_in, v_in, cy, upd;
  logic [CW-1:0]    ch;
  int               p;
  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    a_in   = '0;
    b_in   = '0;
    s_in   = '0;
    sum_n  = '0;
    c_in   = 1'b0;
    v_in   = 1'b0;
    cy     = 1'b0;
    ch     = '0;
    upd    = 1'b0;
    p      = 0;
    for (int k = 0; k < NStages; k++) begin
      p     = (k > 0) ? k - 1 : 0;
      a_in  = (k == 0) ? Data0 : a_q[p];
      b_in  = (k == 0) ? (Sub ? ~Data1 : Data1) : b_q[p];
      s_in  = (k == 0) ? '0 : s_q[p];
      c_in  = (k == 0) ? Sub : c_q[p];
      v_in  = (k == 0) ? In_Valid : v_q[p];
      {cy, ch} = {1'b0, a_in[k*CW +: CW]} + {1'b0, b_in[k*CW +: CW]} + {{CW{1'b0}}, c_in};
      sum_n = s_in;
      sum_n[k*CW +: CW] = ch;
      // the output stage only loads on a valid operation so results hold otherwise
      upd   = Enable && !Flush && (k != NStages - 1 || v_in);
      a_d[k] = upd ? a_in : a_q[k];
      b_d[k] = upd ? b_in : b_q[k];
      s_d[k] = upd ? sum_n : s_q[k];
      c_d[k] = upd ? cy : c_q[k];
      v_d[k] = Flush ? 1'b0 : (Enable ? v_in : v_q[k]);
      if (k == NStages - 1 && upd) begin
        ovf_d  = (a_in[NBits-1] == b_in[NBits-1]) && (sum_n[NBits-1] != a_in[NBits-1]);
        zero_d = (sum_n == '0);
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NStages; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int k = 0; k < NStages; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign Out_Valid = v_q[NStages-1];
  assign Result    = s_q[NStages-1];
  assign Carry_Out = c_q[NStages-1];
  assign Overflow  = ovf_q;
  assign Zero      = zero_q;
endmodule
